// File: rtl/traffic_ctrl_n.sv
// N-way traffic light controller: one direction owns GREEN/YELLOW at a time,
// separated by an ALLRED clearance, with emergency preempt to all-red.
module traffic_ctrl_n #(
  parameter int NUM_DIR    = 2,
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 16,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DIR-1:0]         traffic,
  input  logic                       emg,
  output logic [2*NUM_DIR-1:0]       light,
  output logic [$clog2(NUM_DIR)-1:0] dir_o,
  output logic [1:0]                 phase
);

  localparam int DW = $clog2(NUM_DIR);
  localparam int TW = (MAX_GREEN > 1) ? $clog2(MAX_GREEN) : 1;

  localparam logic [31:0] MIN_M1 = 32'(MIN_GREEN - 1);
  localparam logic [31:0] MAX_M1 = 32'(MAX_GREEN - 1);
  localparam logic [31:0] YEL_M1 = 32'(YELLOW_CYC - 1);
  localparam logic [31:0] AR_M1  = 32'(ALLRED_CYC - 1);

  typedef enum logic [1:0] {
    S_GREEN  = 2'b00,
    S_YELLOW = 2'b01,
    S_ALLRED = 2'b10
  } state_t;

  state_t              state_q, state_d;
  logic [DW-1:0]       dir_q, dir_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic [2*NUM_DIR-1:0] light_q, light_d;

  logic [31:0]         tmr_ext;
  logic                others;
  logic                own;
  logic [DW-1:0]       nxt_dir;
  logic                found;
  int                  idx;

  function automatic logic [2*NUM_DIR-1:0] decode_light(state_t st, logic [DW-1:0] d);
    logic [2*NUM_DIR-1:0] lt;
    lt = {NUM_DIR{2'b10}};
    case (st)
      S_GREEN:  lt[2*int'(d) +: 2] = 2'b00;
      S_YELLOW: lt[2*int'(d) +: 2] = 2'b01;
      default:  lt = {NUM_DIR{2'b10}};
    endcase
    return lt;
  endfunction

  assign tmr_ext = 32'(tmr_q);
  assign own     = traffic[dir_q];
  assign others  = |(traffic & ~(NUM_DIR'(1) << dir_q));

  // Round-robin search for the next waiting direction after the current owner.
  always_comb begin
    nxt_dir = (int'(dir_q) == NUM_DIR - 1) ? '0 : dir_q + DW'(1);
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k < NUM_DIR; k++) begin
      idx = (int'(dir_q) + k) % NUM_DIR;
      if (!found && traffic[idx]) begin
        found   = 1'b1;
        nxt_dir = DW'(idx);
      end else begin
        found = found;
      end
    end
  end

  // Phase sequencing, owner hand-over and phase timer.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      S_GREEN: begin
        if (emg) begin
          state_d = S_YELLOW;
        end else if ((tmr_ext >= MIN_M1) && others && (!own || (tmr_ext >= MAX_M1))) begin
          state_d = S_YELLOW;
        end else begin
          state_d = S_GREEN;
        end
      end
      S_YELLOW: begin
        if (tmr_ext == YEL_M1) begin
          state_d = S_ALLRED;
        end else begin
          state_d = S_YELLOW;
        end
      end
      S_ALLRED: begin
        if ((tmr_ext >= AR_M1) && !emg) begin
          state_d = S_GREEN;
          dir_d   = nxt_dir;
        end else begin
          state_d = S_ALLRED;
        end
      end
      default: begin
        state_d = S_ALLRED;
      end
    endcase

    if (state_d != state_q) begin
      tmr_d = '0;
    end else if (tmr_ext < MAX_M1) begin
      tmr_d = tmr_q + TW'(1);
    end else begin
      tmr_d = tmr_q;
    end

    light_d = decode_light(state_d, dir_d);
  end

  // State, owner, timer and lamp registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_GREEN;
      dir_q   <= '0;
      tmr_q   <= '0;
      light_q <= decode_light(S_GREEN, '0);
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tmr_q   <= tmr_d;
      light_q <= light_d;
    end
  end

  assign light = light_q;
  assign phase = state_q;
  assign dir_o = dir_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Scoreboard bench for traffic_ctrl_n: per-cycle expected phase/owner/lamps
// are queued from the scenario timing and checked one cycle at a time.
module tb_traffic_ctrl_n;

  localparam int ND = 3;

  logic          clk;
  logic          rst;
  logic [ND-1:0] traffic;
  logic          emg;
  logic [2*ND-1:0] light;
  logic [1:0]    dir_o;
  logic [1:0]    phase;

  typedef struct packed {
    logic [1:0] ph;
    logic [1:0] d;
    logic [5:0] lt;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   fails     = 0;

  traffic_ctrl_n #(
    .NUM_DIR(3), .MIN_GREEN(4), .MAX_GREEN(8), .YELLOW_CYC(2), .ALLRED_CYC(1)
  ) dut (
    .clk(clk), .rst(rst), .traffic(traffic), .emg(emg),
    .light(light), .dir_o(dir_o), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] exp_light(logic [1:0] ph, logic [1:0] d);
    logic [5:0] lt;
    for (int i = 0; i < ND; i++) begin
      if (ph == 2'b00 && d == 2'(i))      lt[2*i +: 2] = 2'b00;
      else if (ph == 2'b01 && d == 2'(i)) lt[2*i +: 2] = 2'b01;
      else                                 lt[2*i +: 2] = 2'b10;
    end
    return lt;
  endfunction

  task automatic push(input logic [1:0] ph, input logic [1:0] d, input int n);
    exp_t e;
    e.ph = ph;
    e.d  = d;
    e.lt = exp_light(ph, d);
    repeat (n) sb.push_back(e);
  endtask

  // Compare the current cycle with the queue head, then step to the next cycle.
  task automatic drain(input string name);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      tests_run++;
      if ({phase, dir_o, light} !== {e.ph, e.d, e.lt}) begin
        fails++;
        $display("FAIL %s cyc %0d: phase/dir/light got %b/%0d/%b want %b/%0d/%b",
                 name, cyc, phase, dir_o, light, e.ph, e.d, e.lt);
      end
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    traffic = 3'b000;
    emg     = 1'b0;
    do_reset();
    tests_run++;
    if (light !== 6'b10_10_00) begin
      fails++;
      $display("FAIL reset_light: got %b want %b", light, 6'b10_10_00);
    end
    tests_run++;
    if (phase !== 2'b00) begin
      fails++;
      $display("FAIL reset_phase: got %b want 00", phase);
    end
    tests_run++;
    if (dir_o !== 2'd0) begin
      fails++;
      $display("FAIL reset_dir: got %0d want 0", dir_o);
    end
  endtask

  task automatic test_idle_rest();
    traffic = 3'b000;
    emg     = 1'b0;
    do_reset();
    push(2'b00, 2'd0, 50);
    drain("idle_rest");
  endtask

  task automatic test_single_request();
    traffic = 3'b010;
    emg     = 1'b0;
    do_reset();
    push(2'b00, 2'd0, 4);
    push(2'b01, 2'd0, 2);
    push(2'b10, 2'd0, 1);
    push(2'b00, 2'd1, 20);
    drain("single_req");
  endtask

  task automatic test_all_busy();
    traffic = 3'b111;
    emg     = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(2'b00, 2'(k), 8);
      push(2'b01, 2'(k), 2);
      push(2'b10, 2'(k), 1);
    end
    push(2'b00, 2'd0, 8);
    drain("all_busy");
  endtask

  task automatic test_skip_idle_dir();
    traffic = 3'b100;
    emg     = 1'b0;
    do_reset();
    push(2'b00, 2'd0, 4);
    push(2'b01, 2'd0, 2);
    push(2'b10, 2'd0, 1);
    push(2'b00, 2'd2, 10);
    drain("skip_dir1");
  endtask

  task automatic test_emergency();
    traffic = 3'b011;
    emg     = 1'b0;
    do_reset();
    push(2'b00, 2'd0, 1);
    drain("emg_pre");
    emg = 1'b1;
    push(2'b00, 2'd0, 1);
    push(2'b01, 2'd0, 2);
    push(2'b10, 2'd0, 5);
    drain("emg_hold");
    emg = 1'b0;
    push(2'b10, 2'd0, 1);
    push(2'b00, 2'd1, 4);
    drain("emg_release");
  endtask

  task automatic test_reset_mid_yellow();
    traffic = 3'b100;
    emg     = 1'b0;
    do_reset();
    push(2'b00, 2'd0, 4);
    push(2'b01, 2'd0, 2);
    push(2'b10, 2'd0, 1);
    push(2'b00, 2'd2, 1);
    drain("to_green2");
    traffic = 3'b001;
    push(2'b00, 2'd2, 3);
    push(2'b01, 2'd2, 1);
    drain("to_yellow2");
    emg = 1'b1;
    do_reset();
    emg = 1'b0;
    push(2'b00, 2'd0, 6);
    drain("rst_mid_yellow");
  endtask

  initial begin
    rst     = 1'b1;
    traffic = 3'b000;
    emg     = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_idle_rest();
    test_single_request();
    test_all_busy();
    test_skip_idle_dir();
    test_emergency();
    test_reset_mid_yellow();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/traffic_ctrl_n.md
TRAFFIC_CTRL_N -- requirements
Module: traffic_ctrl_n

Interface
REQ-001 Parameter NUM_DIR, default 2: number of approach directions; legal range 2..16.
REQ-002 Parameter MIN_GREEN, default 4: minimum green length in cycles; legal range at least 1.
REQ-003 Parameter MAX_GREEN, default 16: green length in cycles after which a contested green is forced to end; legal when MAX_GREEN >= MIN_GREEN.
REQ-004 Parameter YELLOW_CYC, default 3: yellow length in cycles; legal range at least 1.
REQ-005 Parameter ALLRED_CYC, default 1: all-red clearance length in cycles; legal range at least 1.
REQ-006 Port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-007 Port rst, input, width 1: reset, synchronous, active-low.
REQ-008 Port traffic, input, width NUM_DIR: bit i=1 means traffic is present or waiting at direction i.
REQ-009 Port emg, input, width 1: emergency preempt; while it is 1 the block drives all directions to red.
REQ-010 Port light, output, width 2*NUM_DIR: light[2i+1:2i] is the lamp for direction i; 00=green, 01=yellow, 10=red; 11 is never driven.
REQ-011 Port dir_o, output, width clog2(NUM_DIR): index of the direction that currently owns the phase.
REQ-012 Port phase, output, width 2: current phase; 00=GREEN, 01=YELLOW, 10=ALLRED.

Function
REQ-013 The block SHALL implement a registered FSM with states GREEN, YELLOW and ALLRED, plus a registered owner index dir and a cycle timer tmr.
REQ-014 tmr SHALL clear to 0 on every state change, increment by 1 otherwise, and saturate at MAX_GREEN-1; its width SHALL hold MAX_GREEN-1.
REQ-015 "others" SHALL mean traffic with bit dir masked off being nonzero.
REQ-016 In GREEN, the block SHALL go to YELLOW when emg=1, regardless of tmr.
REQ-017 In GREEN with emg=0, the block SHALL go to YELLOW when tmr >= MIN_GREEN-1, others is true, and either traffic[dir]=0 or tmr >= MAX_GREEN-1.
REQ-018 In GREEN, if no other direction has traffic, the block SHALL stay in GREEN indefinitely (rest on green).
REQ-019 In YELLOW, the block SHALL go to ALLRED when tmr == YELLOW_CYC-1; emg SHALL NOT shorten yellow.
REQ-020 In ALLRED, the block SHALL go to GREEN when tmr >= ALLRED_CYC-1 and emg=0; while emg=1 it SHALL remain in ALLRED.
REQ-021 On the ALLRED to GREEN edge, dir SHALL load the first index j scanning dir+1, dir+2, ... (mod NUM_DIR) with traffic[j]=1, excluding dir.
REQ-022 If no such j exists on that edge, dir SHALL load (dir+1) mod NUM_DIR.
REQ-023 dir SHALL change only on the ALLRED to GREEN edge.
REQ-024 light SHALL be a function of the registered state only.
REQ-025 In GREEN, light SHALL show 00 for dir; in YELLOW, 01 for dir; all other directions, and every direction in ALLRED, SHALL show 10.
REQ-026 Consequence of REQ-014 to REQ-020: green lasts at least MIN_GREEN cycles (except under emg), yellow lasts exactly YELLOW_CYC cycles, and all-red lasts at least ALLRED_CYC cycles.
REQ-027 phase and dir_o SHALL mirror the registered state and dir.

Reset
REQ-028 When rst=0 at a rising clk, the block SHALL load state=GREEN, dir=0 and tmr=0 from any state, including mid-YELLOW or mid-ALLRED.
REQ-029 After that reset edge, light SHALL show direction 0 green and all others red, phase=00 and dir_o=0; rst SHALL take priority over emg.

Verification
REQ-030 The bench SHALL cover the following scenarios with NUM_DIR=3, MIN_GREEN=4, MAX_GREEN=8, YELLOW_CYC=2, ALLRED_CYC=1:
- Reset, then traffic=000 and emg=0 for 50 cycles -> light=6'b10_10_00 constant, phase=00.
- traffic=3'b010 from reset release -> green0 for 4 cycles, yellow0 for 2, all-red for 1, then green1 (phase=00, dir_o=1) in the 8th cycle; green1 then holds indefinitely.
- traffic=3'b111 held -> each green lasts exactly 8 cycles; owner order is 0,1,2,0; yellow is 2 cycles and all-red 1 cycle between greens.
- traffic=3'b100 while green0 (traffic[1]=0) -> after the minimum green, the next owner is 2 (direction 1 skipped).
- emg=1 at green0 with tmr=1 -> YELLOW next cycle; ALLRED (light=6'b10_10_10) holds while emg=1; on release, green1 follows if traffic[1]=1.
- rst=0 during YELLOW of dir2 -> next cycle phase=00, dir_o=0, light=6'b10_10_00.
